// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the FIFO write-port arbiter.
// The state enum, the clog2 helper and default index widths live here.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  // Ceiling log2, but never narrower than one bit so indices stay legal.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    if (result == 0) begin
      result = 1;
    end
    return result;
  endfunction

  localparam int DEFAULT_NUM_REQ    = 4;
  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_MAX_BURST  = 4;
  localparam int DEFAULT_IDX_W      = clog2(DEFAULT_NUM_REQ);
  localparam int DEFAULT_CNT_W      = clog2(DEFAULT_MAX_BURST + 1);

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Rotate-priority encoder: first set request at or above rr_ptr, wrapping to 0.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = DEFAULT_NUM_REQ,
  parameter int IDX_W   = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [IDX_W-1:0]   winner,
  output logic               any
);

  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int offset);
    int sum;
    sum = int'(base) + offset;
    if (sum >= NUM_REQ) begin
      sum = sum - NUM_REQ;
    end
    return IDX_W'(sum);
  endfunction

  // Scan from the farthest offset down so the nearest set bit wins last.
  always_comb begin
    winner = '0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      if (req[wrap_add(rr_ptr, off)]) begin
        winner = wrap_add(rr_ptr, off);
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one fifo_async write port among NUM_REQ producers.
// Honours fifo_full, caps bursts at MAX_BURST words and rotates priority after each burst.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int  NUM_REQ    = DEFAULT_NUM_REQ,
  parameter int  DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int  MAX_BURST  = DEFAULT_MAX_BURST,
  localparam int IDX_W      = clog2(NUM_REQ),
  localparam int CNT_W      = clog2(MAX_BURST + 1)
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            ack,
  input  logic                          fifo_full,
  output logic                          fifo_write_en,
  output logic [DATA_WIDTH-1:0]         fifo_data_in,
  output logic                          busy,
  output logic [IDX_W-1:0]              owner
);

  state_t           state;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] winner;
  logic [IDX_W-1:0] next_ptr;
  logic [CNT_W-1:0] burst_cnt;
  logic             any;
  logic             owner_req;
  logic             accept;
  logic             last_word;
  logic             exit_burst;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req    (req),
    .rr_ptr (rr_ptr),
    .winner (winner),
    .any    (any)
  );

  assign owner_req  = req[owner];
  assign accept     = (state == BURST) && owner_req && !fifo_full;
  assign last_word  = accept && (burst_cnt == CNT_W'(MAX_BURST - 1));
  assign exit_burst = (state == BURST) && (last_word || !owner_req);
  assign next_ptr   = (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + IDX_W'(1);

  // Reset low must silence the write port immediately, even mid-burst.
  assign fifo_write_en = accept && reset_n;
  assign ack           = (accept && reset_n) ? (NUM_REQ'(1) << owner) : '0;
  assign fifo_data_in  = (state == BURST) ? req_data[int'(owner)*DATA_WIDTH +: DATA_WIDTH] : '0;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      owner     <= '0;
      burst_cnt <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any) begin
            owner     <= winner;
            burst_cnt <= '0;
            state     <= BURST;
            busy      <= 1'b1;
          end
        end
        BURST: begin
          if (accept) begin
            burst_cnt <= burst_cnt + CNT_W'(1);
          end
          // A capped last word and a release in the same cycle give one exit.
          if (exit_burst) begin
            state  <= IDLE;
            busy   <= 1'b0;
            rr_ptr <= next_ptr;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench: directed scenarios with literal expectations plus a random run
// compared each cycle against a behavioural arbiter model and a FIFO scoreboard.
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [N-1:0]  req = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]  ack;
  logic          fifo_full = 1'b0;
  logic          fifo_write_en;
  logic [DW-1:0] fifo_data_in;
  logic          busy;
  logic [1:0]    owner;

  int assert_count = 0;
  int fail_count   = 0;

  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] ack_q[$];

  bit model_valid = 0;
  bit m_burst;
  int m_owner, m_cnt, m_ptr;
  int run_len = 0;

  logic [N-1:0]  exp_ack;
  logic          exp_wen;
  logic [DW-1:0] exp_data;
  logic          acc;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(
    .NUM_REQ    (N),
    .DATA_WIDTH (DW),
    .MAX_BURST  (MB)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .req           (req),
    .req_data      (req_data),
    .ack           (ack),
    .fifo_full     (fifo_full),
    .fifo_write_en (fifo_write_en),
    .fifo_data_in  (fifo_data_in),
    .busy          (busy),
    .owner         (owner)
  );

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    assert_count++;
    if (actual != expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic rn, input logic [N-1:0] r, input logic full);
    next_cycle();
    reset_n   = rn;
    req       = r;
    fifo_full = full;
  endtask

  task automatic do_reset();
    applyStimulus(1'b0, '0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0);
    @(negedge clk);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_owner", owner, 0);
    checkOutput("reset_write_en", fifo_write_en, 0);
    fifo_q.delete();
    ack_q.delete();
  endtask

  // Behavioural model: grant rotation, burst cap and release, evaluated once per cycle.
  always @(negedge clk) begin
    if (!model_valid) begin
      if (!reset_n) begin
        model_valid = 1;
        m_burst = 0; m_owner = 0; m_cnt = 0; m_ptr = 0;
      end
    end else begin
      acc      = m_burst && req[m_owner] && !fifo_full;
      exp_wen  = acc && reset_n;
      exp_ack  = exp_wen ? N'(1 << m_owner) : '0;
      exp_data = m_burst ? req_data[m_owner*DW +: DW] : '0;
      checkOutput("model_write_en", fifo_write_en, exp_wen);
      checkOutput("model_ack", ack, exp_ack);
      checkOutput("model_data", fifo_data_in, exp_data);
      checkOutput("model_busy", busy, m_burst);
      checkOutput("model_owner", owner, m_owner);

      if (!busy) run_len = 0;
      if (fifo_write_en) begin
        fifo_q.push_back(fifo_data_in);
        run_len++;
        checkOutput("burst_len_le_max", run_len <= MB, 1);
        checkOutput("write_while_full", fifo_full, 0);
      end
      for (int i = 0; i < N; i++)
        if (ack[i]) ack_q.push_back(req_data[i*DW +: DW]);

      if (!reset_n) begin
        m_burst = 0; m_owner = 0; m_cnt = 0; m_ptr = 0;
      end else if (!m_burst) begin
        if (req != 0) begin
          for (int k = N - 1; k >= 0; k--)
            if (req[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
          m_cnt   = 0;
          m_burst = 1;
        end
      end else begin
        if (acc) m_cnt++;
        if ((acc && m_cnt == MB) || !req[m_owner]) begin
          m_burst = 0;
          m_ptr   = (m_owner + 1) % N;
        end
      end
    end
  end

  logic [N-1:0] single_ack[7] = '{4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0001};
  logic         single_busy[7] = '{0, 1, 1, 1, 1, 0, 1};
  int           rot_exp[17] = '{0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0};
  logic [N-1:0] last_ack;

  initial begin
    // Single requester: four-word burst, one bubble, then it wins again.
    do_reset();
    req_data = 32'h00_00_00_5A;
    applyStimulus(1'b1, 4'b0001, 1'b0);
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      checkOutput("single_ack", ack, single_ack[k]);
      checkOutput("single_busy", busy, single_busy[k]);
      if (k == 5) checkOutput("single_rr_ptr", dut.rr_ptr, 1);
      if (k < 6) next_cycle();
    end

    // Rotation with everyone requesting; data equals requester index.
    do_reset();
    req_data = {8'd3, 8'd2, 8'd1, 8'd0};
    applyStimulus(1'b1, 4'b1111, 1'b0);
    for (int k = 0; k < 22; k++) begin
      @(negedge clk);
      if (k < 21) next_cycle();
    end
    @(posedge clk);
    checkOutput("rotation_count", fifo_q.size(), 17);
    for (int i = 0; i < 17 && i < fifo_q.size(); i++)
      checkOutput("rotation_order", fifo_q[i], rot_exp[i]);

    // Backpressure on owner 2 after two words.
    do_reset();
    req_data = 32'h00_A0_00_00;
    applyStimulus(1'b1, 4'b0100, 1'b0);
    @(negedge clk); checkOutput("bp_idle_ack", ack, 0);
    next_cycle();
    @(negedge clk); checkOutput("bp_word1_ack", ack, 4'b0100);
    next_cycle(); req_data[23:16] = 8'hA1;
    @(negedge clk); checkOutput("bp_word2_ack", ack, 4'b0100);
    next_cycle(); req_data[23:16] = 8'hA2; fifo_full = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checkOutput("bp_full_write_en", fifo_write_en, 0);
      checkOutput("bp_full_ack", ack, 0);
      next_cycle();
      if (k == 4) fifo_full = 1'b0;
    end
    @(negedge clk); checkOutput("bp_word3_data", fifo_data_in, 8'hA2);
    next_cycle(); req_data[23:16] = 8'hA3;
    @(negedge clk); checkOutput("bp_word4_ack", ack, 4'b0100);
    next_cycle(); req = '0;
    @(negedge clk); checkOutput("bp_exit_busy", busy, 0);
    @(posedge clk);
    checkOutput("bp_count", fifo_q.size(), 4);
    for (int i = 0; i < 4 && i < fifo_q.size(); i++)
      checkOutput("bp_order", fifo_q[i], 8'hA0 + i);

    // Early release by owner 1 hands the next burst to owner 3, then the pointer wraps.
    do_reset();
    req_data = 32'h44_33_22_11;
    applyStimulus(1'b1, 4'b1010, 1'b0);
    @(negedge clk); checkOutput("rel_idle_ack", ack, 0);
    next_cycle();
    @(negedge clk); checkOutput("rel_owner1_ack", ack, 4'b0010);
    next_cycle(); req = 4'b1000;
    @(negedge clk); checkOutput("rel_drop_ack", ack, 0); checkOutput("rel_drop_busy", busy, 1);
    next_cycle(); req = 4'b1010;
    @(negedge clk); checkOutput("rel_bubble_busy", busy, 0);
    next_cycle();
    @(negedge clk); checkOutput("rel_owner3_ack", ack, 4'b1000); checkOutput("rel_owner3", owner, 3);
    next_cycle(); req = 4'b0010;
    @(negedge clk); checkOutput("rel_owner3_drop_ack", ack, 0);
    next_cycle();
    @(negedge clk); checkOutput("rel_wrap_ptr", dut.rr_ptr, 0); checkOutput("rel_wrap_busy", busy, 0);
    next_cycle();
    @(negedge clk); checkOutput("rel_owner1_again", ack, 4'b0010); checkOutput("rel_owner1_idx", owner, 1);

    // Reset asserted during the second word of a burst by requester 2.
    do_reset();
    req_data = 32'h00_77_00_00;
    applyStimulus(1'b1, 4'b0100, 1'b0);
    next_cycle();
    @(negedge clk); checkOutput("rst_word1_ack", ack, 4'b0100);
    next_cycle(); reset_n = 1'b0;
    @(negedge clk); checkOutput("rst_forced_write_en", fifo_write_en, 0); checkOutput("rst_forced_ack", ack, 0);
    next_cycle(); reset_n = 1'b1;
    @(negedge clk); checkOutput("rst_after_busy", busy, 0); checkOutput("rst_after_owner", owner, 0);

    // Random traffic and backpressure against the model and a FIFO scoreboard.
    do_reset();
    applyStimulus(1'b1, '0, 1'b0);
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge clk);
      last_ack = ack;
      next_cycle();
      for (int i = 0; i < N; i++) begin
        if (req[i]) begin
          if (last_ack[i]) begin
            if ($urandom_range(1, 0) == 1) req_data[i*DW +: DW] = 8'($urandom);
            else req[i] = 1'b0;
          end else if ($urandom_range(15, 0) == 0) begin
            req[i] = 1'b0;
          end
        end else if ($urandom_range(2, 0) == 0) begin
          req[i] = 1'b1;
          req_data[i*DW +: DW] = 8'($urandom);
        end
      end
      fifo_full = ($urandom_range(3, 0) == 0);
    end
    req = '0;
    repeat (3) next_cycle();
    checkOutput("scoreboard_nonempty", fifo_q.size() > 100, 1);
    checkOutput("scoreboard_depth", fifo_q.size(), ack_q.size());
    for (int i = 0; i < fifo_q.size() && i < ack_q.size(); i++)
      checkOutput("scoreboard_order", fifo_q[i], ack_q[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
